// File: rtl/accel_spi_pkg.sv
// Shared constants for the accelerometer SPI responder: register map, reset values, FSM encoding.
// ACCEL_SPI_DATA_READY_INT_EN makes INT_ENABLE/INT_MAP writable.
package accel_spi_pkg;
  localparam logic [5:0] A_DEVID       = 6'h00;
  localparam logic [5:0] A_BW_RATE     = 6'h2C;
  localparam logic [5:0] A_POWER_CTL   = 6'h2D;
  localparam logic [5:0] A_INT_ENABLE  = 6'h2E;
  localparam logic [5:0] A_INT_MAP     = 6'h2F;
  localparam logic [5:0] A_INT_SOURCE  = 6'h30;
  localparam logic [5:0] A_DATA_FORMAT = 6'h31;
  localparam logic [5:0] A_DATAX0      = 6'h32;
  localparam logic [5:0] A_DATAX1      = 6'h33;
  localparam logic [5:0] A_DATAY0      = 6'h34;
  localparam logic [5:0] A_DATAY1      = 6'h35;
  localparam logic [5:0] A_DATAZ0      = 6'h36;
  localparam logic [5:0] A_DATAZ1      = 6'h37;
  localparam logic [5:0] A_FIFO_CTL    = 6'h38;

  localparam logic [7:0] BW_RATE_RST = 8'h0A;
  localparam logic [7:0] RW_RST      = 8'h00;

  localparam logic [63:0] WR_MASK_BASE = (64'd1 << A_BW_RATE) | (64'd1 << A_POWER_CTL)
                                       | (64'd1 << A_DATA_FORMAT) | (64'd1 << A_FIFO_CTL);
`ifdef ACCEL_SPI_DATA_READY_INT_EN
  localparam logic [63:0] WR_MASK = WR_MASK_BASE | (64'd1 << A_INT_ENABLE) | (64'd1 << A_INT_MAP);
`else
  localparam logic [63:0] WR_MASK = WR_MASK_BASE;
`endif

  typedef enum logic [1:0] {IDLE, CMD, RD, WR} state_t;

  function automatic logic is_data_addr(input logic [5:0] a);
    return (a >= A_DATAX0) && (a <= A_DATAZ1);
  endfunction
endpackage

// File: rtl/spi_pin_sync.sv
// Multi-stage synchronizer for one SPI pin with rise/fall strobes and a delayed level.
// lvl lags the strobes by one cycle, so it reads "before the edge" on a strobe cycle.
module spi_pin_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {STAGES{RST_VAL}};
      lvl  <= RST_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      lvl  <= sync[STAGES-1];
    end
  end

  assign rise = sync[STAGES-1] & ~lvl;
  assign fall = ~sync[STAGES-1] & lvl;
endmodule

// File: rtl/accel_spi_responder.sv
// SPI mode-3 target emulating the accelerometer register map, fed by a parallel sample port.
// ACCEL_SPI_DATA_READY_INT_EN enables the int1 data-ready interrupt path.
module accel_spi_responder
  import accel_spi_pkg::*;
#(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  input  logic        spi_csn,
  input  logic        spi_sclk,
  input  logic        spi_sdi,
  output logic        spi_sdo,
  output logic        spi_sdo_oe,
  output logic        int1,
  output logic        busy,
  output logic [7:0]  reg_power_ctl
);
  logic csn_lvl, csn_rise, csn_fall, sclk_rise, sclk_fall, sdi_lvl;
  logic unused_sclk_lvl, unused_sdi_rise, unused_sdi_fall;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn (
    .clk(clk), .rst(rst), .din(spi_csn), .lvl(csn_lvl), .rise(csn_rise), .fall(csn_fall));
  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk (
    .clk(clk), .rst(rst), .din(spi_sclk), .lvl(unused_sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdi (
    .clk(clk), .rst(rst), .din(spi_sdi), .lvl(sdi_lvl), .rise(unused_sdi_rise), .fall(unused_sdi_fall));

  assign busy = ~csn_lvl;

  state_t      state, state_nxt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift, tx, rdata, rx_byte;
  logic [5:0]  addr;
  logic        mb, byte_done, wr_en;
  logic [7:0]  bw_rate, power_ctl, int_enable, int_map, data_format, fifo_ctl;
  logic [15:0] dx, dy, dz, px, py, pz, lx, ly, lz;
  logic        pend, data_ready, rd_hit, load_now;

  assign rx_byte       = {shift[6:0], sdi_lvl};
  assign byte_done     = sclk_rise && (bit_cnt == 3'd7);
  assign wr_en         = (state == WR) && byte_done && !csn_rise && WR_MASK[addr];
  assign reg_power_ctl = power_ctl;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (csn_fall) state_nxt = CMD;
      CMD:     if (byte_done) state_nxt = rx_byte[7] ? RD : WR;
      default: ;
    endcase
    if (csn_rise) state_nxt = IDLE;
  end

  // A fresh sample on the CSN-rise cycle beats whatever is pending.
  always_comb begin
    load_now = 1'b0;
    lx = sample_x;
    ly = sample_y;
    lz = sample_z;
    if (sample_valid && (csn_rise || !busy)) begin
      load_now = 1'b1;
    end else if (csn_rise && pend) begin
      load_now = 1'b1;
      lx = px;
      ly = py;
      lz = pz;
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (addr)
      A_DEVID:       rdata = DEVID;
      A_BW_RATE:     rdata = bw_rate;
      A_POWER_CTL:   rdata = power_ctl;
      A_INT_ENABLE:  rdata = int_enable;
      A_INT_MAP:     rdata = int_map;
      A_INT_SOURCE:  rdata = {data_ready, 7'd0};
      A_DATA_FORMAT: rdata = data_format;
      A_DATAX0:      rdata = dx[7:0];
      A_DATAX1:      rdata = dx[15:8];
      A_DATAY0:      rdata = dy[7:0];
      A_DATAY1:      rdata = dy[15:8];
      A_DATAZ0:      rdata = dz[7:0];
      A_DATAZ1:      rdata = dz[15:8];
      A_FIFO_CTL:    rdata = fifo_ctl;
      default:       ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0; shift <= '0; tx <= '0; addr <= '0; mb <= 1'b0;
      spi_sdo <= 1'b0; spi_sdo_oe <= 1'b0; rd_hit <= 1'b0;
    end else if (csn_rise || csn_fall) begin
      bit_cnt    <= '0;
      spi_sdo    <= 1'b0;
      spi_sdo_oe <= 1'b0;
      rd_hit     <= 1'b0;
    end else if (state != IDLE) begin
      if (sclk_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        shift   <= rx_byte;
        if (byte_done) begin
          if (state == CMD) begin
            addr <= rx_byte[5:0];
            mb   <= rx_byte[6];
          end else if (mb) begin
            addr <= addr + 6'd1;
          end
        end
      end
      // Byte boundary: the first falling edge of each data byte fetches the register.
      if (sclk_fall && state == RD) begin
        spi_sdo_oe <= 1'b1;
        if (bit_cnt == 3'd0) begin
          spi_sdo <= rdata[7];
          tx      <= {rdata[6:0], 1'b0};
          if (is_data_addr(addr)) rd_hit <= 1'b1;
        end else begin
          spi_sdo <= tx[7];
          tx      <= {tx[6:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bw_rate <= BW_RATE_RST; power_ctl <= RW_RST; int_enable <= RW_RST;
      int_map <= RW_RST; data_format <= RW_RST; fifo_ctl <= RW_RST;
    end else if (wr_en) begin
      case (addr)
        A_BW_RATE:     bw_rate     <= rx_byte;
        A_POWER_CTL:   power_ctl   <= rx_byte;
        A_INT_ENABLE:  int_enable  <= rx_byte;
        A_INT_MAP:     int_map     <= rx_byte;
        A_DATA_FORMAT: data_format <= rx_byte;
        A_FIFO_CTL:    fifo_ctl    <= rx_byte;
        default:       ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dx <= '0; dy <= '0; dz <= '0; px <= '0; py <= '0; pz <= '0;
      pend <= 1'b0; data_ready <= 1'b0;
    end else begin
      if (load_now) begin
        dx <= lx; dy <= ly; dz <= lz;
      end
      if (sample_valid && busy && !csn_rise) begin
        pend <= 1'b1;
        px <= sample_x; py <= sample_y; pz <= sample_z;
      end else if (csn_rise) begin
        pend <= 1'b0;
      end
      if (load_now)               data_ready <= 1'b1;
      else if (csn_rise && rd_hit) data_ready <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) int1 <= 1'b0;
`ifdef ACCEL_SPI_DATA_READY_INT_EN
    else     int1 <= data_ready & int_enable[7] & ~int_map[7];
`else
    else     int1 <= 1'b0;
`endif
  end
endmodule

// File: tb/tb_accel_spi_responder.sv
// Scoreboard bench for accel_spi_responder: SPI mode-3 master tasks, expected bytes queued per read.
module tb_accel_spi_responder;
  import accel_spi_pkg::*;

  localparam int HALF = 80;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [15:0] sample_x, sample_y, sample_z;
  logic        spi_csn, spi_sclk, spi_sdi;
  logic        spi_sdo, spi_sdo_oe, int1, busy;
  logic [7:0]  reg_power_ctl;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  accel_spi_responder dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid),
    .sample_x(sample_x), .sample_y(sample_y), .sample_z(sample_z),
    .spi_csn(spi_csn), .spi_sclk(spi_sclk), .spi_sdi(spi_sdi),
    .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe), .int1(int1), .busy(busy),
    .reg_power_ctl(reg_power_ctl));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic csn_low;
    spi_csn = 1'b0;
    #(HALF);
    chk("busy_hi", busy, 1);
  endtask

  task automatic csn_high;
    #(HALF);
    spi_csn = 1'b1;
    #(2*HALF);
    chk("busy_lo", busy, 0);
    chk("oe_idle", spi_sdo_oe, 0);
  endtask

  // One byte (or nbits) MSB-first; the master samples SDO on the rising edge.
  task automatic xfer(input logic [7:0] mosi, input logic rd, input int nbits);
    logic [7:0] miso;
    miso = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_sclk = 1'b0;
      spi_sdi  = mosi[i];
      #(HALF);
      spi_sclk = 1'b1;
      miso[i]  = spi_sdo;
      if (i == 4) chk("sdo_oe", spi_sdo_oe, rd);
      #(HALF);
    end
    if (rd) begin
      if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
      else                   chk("sdo_byte", miso, exp_q.pop_front());
    end
  endtask

  task automatic rd_txn(input logic [7:0] cmd, input int n);
    csn_low();
    xfer(cmd, 1'b0, 8);
    for (int b = 0; b < n; b++) xfer(8'h00, 1'b1, 8);
    csn_high();
  endtask

  task automatic wr_txn(input logic [7:0] a, input logic [7:0] d);
    csn_low();
    xfer(a, 1'b0, 8);
    xfer(d, 1'b0, 8);
    csn_high();
  endtask

  task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_x = x; sample_y = y; sample_z = z;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic push6(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    exp_q.push_back(x[7:0]); exp_q.push_back(x[15:8]);
    exp_q.push_back(y[7:0]); exp_q.push_back(y[15:8]);
    exp_q.push_back(z[7:0]); exp_q.push_back(z[15:8]);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; sample_valid = 1'b0; sample_x = '0; sample_y = '0; sample_z = '0;
    spi_csn = 1'b1; spi_sclk = 1'b1; spi_sdi = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_sdo", spi_sdo, 0);
    chk("rst_oe", spi_sdo_oe, 0);
    chk("rst_int1", int1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_power", reg_power_ctl, 8'h00);

    // DEVID, non-MB repeat, BW_RATE reset value, address wrap 0x3F -> 0x00
    exp_q.push_back(8'hE5); rd_txn(8'h80, 1);
    exp_q.push_back(8'hE5); exp_q.push_back(8'hE5); rd_txn(8'h80, 2);
    exp_q.push_back(8'h0A); rd_txn(8'hAC, 1);
    exp_q.push_back(8'h00); exp_q.push_back(8'hE5); rd_txn(8'hFF, 2);

    // sample then burst read; DATA_READY clears after the data read
    drive(16'h1234, 16'hFFF0, 16'h0100);
    exp_q.push_back(8'h80); rd_txn(8'hB0, 1);
    push6(16'h1234, 16'hFFF0, 16'h0100); rd_txn(8'hF2, 6);
    exp_q.push_back(8'h00); rd_txn(8'hB0, 1);

    // writes: POWER_CTL, then DEVID is read-only
    wr_txn(8'h2D, 8'h08);
    chk("power_wr", reg_power_ctl, 8'h08);
    exp_q.push_back(8'h08); rd_txn(8'hAD, 1);
    wr_txn(8'h00, 8'h11);
    exp_q.push_back(8'hE5); rd_txn(8'h80, 1);

    // sample arriving mid-read is deferred until CSN rises
    push6(16'h1234, 16'hFFF0, 16'h0100);
    csn_low();
    xfer(8'hF2, 1'b0, 8);
    xfer(8'h00, 1'b1, 8);
    xfer(8'h00, 1'b1, 8);
    drive(16'h5555, 16'hFFF0, 16'h0100);
    for (int b = 0; b < 4; b++) xfer(8'h00, 1'b1, 8);
    csn_high();
    exp_q.push_back(8'h80); rd_txn(8'hB0, 1);
    push6(16'h5555, 16'hFFF0, 16'h0100); rd_txn(8'hF2, 6);
    exp_q.push_back(8'h00); rd_txn(8'hB0, 1);

    // partial write byte is discarded
    csn_low();
    xfer(8'h2D, 1'b0, 8);
    xfer(8'hFF, 1'b0, 4);
    csn_high();
    chk("power_partial", reg_power_ctl, 8'h08);
    wr_txn(8'h2D, 8'h04);
    chk("power_after", reg_power_ctl, 8'h04);

    // data-ready interrupt
    wr_txn(8'h2E, 8'h80);
    chk("int1_pre", int1, 0);
    drive(16'h0A0B, 16'h0000, 16'h0000);
    @(negedge clk);
`ifdef ACCEL_SPI_DATA_READY_INT_EN
    chk("int1_set", int1, 1);
    exp_q.push_back(8'h80); rd_txn(8'hAE, 1);
`else
    chk("int1_tied", int1, 0);
    exp_q.push_back(8'h00); rd_txn(8'hAE, 1);
`endif
    exp_q.push_back(8'h80); rd_txn(8'hB0, 1);
    exp_q.push_back(8'h0B); rd_txn(8'hB2, 1);
    chk("int1_clr", int1, 0);
    exp_q.push_back(8'h00); rd_txn(8'hB0, 1);

    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
